// File: rtl/spi_slave_port.sv
// SPI mode-2 responder: oversampled SCLK/SS/MOSI, MSB-first byte shifting and
// a valid/ack byte interface towards local logic.
module spi_slave_port #(
    parameter logic       IDLE_MISO = 1'b1,
    parameter logic [7:0] FILL_BYTE = 8'hFF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       sclk_i,
    input  logic       ss_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_wr_i,
    output logic       tx_full_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ack_i,
    output logic       rx_overrun_o,
    output logic       tx_underrun_o,
    output logic       busy_o
);

    logic       sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic       ss_s1_q, ss_s2_q, ss_s3_q;
    logic       mosi_s1_q, mosi_s2_q;
    logic [1:0] settle_q;
    logic       ss_ready_q;
    logic       sclk_fall_q, sclk_rise_q, ss_fall_q, ss_rise_q;

    logic       act_q, act_d;
    logic [7:0] txsh_q, txsh_d;
    logic [7:0] rxsh_q, rxsh_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic       armed_q, armed_d;
    logic [7:0] hold_q, hold_d;
    logic       full_q, full_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       ovr_q, ovr_d;
    logic       und_q, und_d;
    logic       miso_q, miso_d;
    logic       busy_q, busy_d;

    logic       load_s;
    logic       complete_s;
    logic [7:0] load_byte_s;

    // Pin synchronizers plus registered edge pulses. SS falling only counts once
    // SS has been seen high on real samples after reset, so a held-low SS is ignored.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_s1_q   <= 1'b1;
            sclk_s2_q   <= 1'b1;
            sclk_s3_q   <= 1'b1;
            ss_s1_q     <= 1'b1;
            ss_s2_q     <= 1'b1;
            ss_s3_q     <= 1'b1;
            mosi_s1_q   <= 1'b1;
            mosi_s2_q   <= 1'b1;
            settle_q    <= 2'b00;
            ss_ready_q  <= 1'b0;
            sclk_fall_q <= 1'b0;
            sclk_rise_q <= 1'b0;
            ss_fall_q   <= 1'b0;
            ss_rise_q   <= 1'b0;
        end else begin
            sclk_s1_q   <= sclk_i;
            sclk_s2_q   <= sclk_s1_q;
            sclk_s3_q   <= sclk_s2_q;
            ss_s1_q     <= ss_i;
            ss_s2_q     <= ss_s1_q;
            ss_s3_q     <= ss_s2_q;
            mosi_s1_q   <= mosi_i;
            mosi_s2_q   <= mosi_s1_q;
            settle_q    <= {settle_q[0], 1'b1};
            ss_ready_q  <= ss_ready_q | (settle_q[1] & ss_s2_q);
            sclk_fall_q <= sclk_s3_q & ~sclk_s2_q;
            sclk_rise_q <= ~sclk_s3_q & sclk_s2_q;
            ss_fall_q   <= ss_ready_q & ss_s3_q & ~ss_s2_q;
            ss_rise_q   <= ~ss_s3_q & ss_s2_q;
        end
    end

    // Frame, shift, holding-register and RX handshake next-state logic.
    always_comb begin
        act_d       = act_q;
        txsh_d      = txsh_q;
        rxsh_d      = rxsh_q;
        bitcnt_d    = bitcnt_q;
        armed_d     = armed_q;
        hold_d      = hold_q;
        full_d      = full_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        ovr_d       = ovr_q;
        und_d       = 1'b0;
        miso_d      = miso_q;
        busy_d      = ~ss_s3_q;
        load_s      = 1'b0;
        complete_s  = 1'b0;
        load_byte_s = full_q ? hold_q : FILL_BYTE;

        if (ss_fall_q) begin
            act_d    = 1'b1;
            bitcnt_d = 3'd0;
            rxsh_d   = 8'h00;
            armed_d  = 1'b0;
            load_s   = 1'b1;
        end else if (ss_rise_q) begin
            act_d    = 1'b0;
            armed_d  = 1'b0;
            miso_d   = IDLE_MISO;
        end else if (act_q && sclk_fall_q) begin
            rxsh_d   = {rxsh_q[6:0], mosi_s2_q};
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
                complete_s = 1'b1;
                armed_d    = 1'b1;
            end else begin
                complete_s = 1'b0;
            end
        end else if (act_q && sclk_rise_q) begin
            if (armed_q) begin
                armed_d = 1'b0;
                load_s  = 1'b1;
            end else begin
                txsh_d  = {txsh_q[6:0], 1'b0};
                miso_d  = txsh_q[6];
            end
        end else begin
            act_d = act_q;
        end

        if (load_s) begin
            txsh_d = load_byte_s;
            miso_d = load_byte_s[7];
            und_d  = ~full_q;
        end else begin
            und_d  = 1'b0;
        end

        // A write in the same cycle as a load re-fills the register after the load took the old byte.
        if (tx_wr_i) begin
            hold_d = tx_data_i;
            full_d = 1'b1;
        end else if (load_s) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end

        if (complete_s) begin
            rx_data_d  = {rxsh_q[6:0], mosi_s2_q};
            rx_valid_d = 1'b1;
            ovr_d      = rx_ack_i ? 1'b0 : (ovr_q | rx_valid_q);
        end else if (rx_ack_i) begin
            rx_valid_d = 1'b0;
            ovr_d      = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            act_q      <= 1'b0;
            txsh_q     <= 8'h00;
            rxsh_q     <= 8'h00;
            bitcnt_q   <= 3'd0;
            armed_q    <= 1'b0;
            hold_q     <= 8'h00;
            full_q     <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
            und_q      <= 1'b0;
            miso_q     <= IDLE_MISO;
            busy_q     <= 1'b0;
        end else begin
            act_q      <= act_d;
            txsh_q     <= txsh_d;
            rxsh_q     <= rxsh_d;
            bitcnt_q   <= bitcnt_d;
            armed_q    <= armed_d;
            hold_q     <= hold_d;
            full_q     <= full_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            ovr_q      <= ovr_d;
            und_q      <= und_d;
            miso_q     <= miso_d;
            busy_q     <= busy_d;
        end
    end

    assign miso_o        = miso_q;
    assign miso_oe_o     = busy_q;
    assign busy_o        = busy_q;
    assign tx_full_o     = full_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign rx_overrun_o  = ovr_q;
    assign tx_underrun_o = und_q;

endmodule

// File: tb/tb_spi_slave_port.sv
// Directed plus randomized bench for spi_slave_port; a byte-level model predicts
// MISO bytes, RX results, underrun pulses and TX_FULL.
module tb_spi_slave_port;

    localparam int HP = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b1;
    logic       ss = 1'b1;
    logic       mosi = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_wr = 1'b0;
    logic       rx_ack = 1'b0;
    logic       miso_o, miso_oe_o, tx_full_o, rx_valid_o, rx_overrun_o, tx_underrun_o, busy_o;
    logic [7:0] rx_data_o;

    int n_vec = 0;
    int n_err = 0;
    int und_seen = 0;

    // Model state
    logic       m_full = 1'b0;
    logic [7:0] m_hold = 8'h00;
    int         m_und = 0;
    logic       e_valid = 1'b0;
    logic       e_ovr = 1'b0;
    logic [7:0] e_data = 8'h00;
    logic [7:0] exp_tx [4];
    logic [7:0] mosi_b [4];
    logic [7:0] miso_b [4];

    spi_slave_port dut (
        .clk_i(clk), .rst_ni(rst_n), .sclk_i(sclk), .ss_i(ss), .mosi_i(mosi),
        .miso_o(miso_o), .miso_oe_o(miso_oe_o), .tx_data_i(tx_data), .tx_wr_i(tx_wr),
        .tx_full_o(tx_full_o), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
        .rx_ack_i(rx_ack), .rx_overrun_o(rx_overrun_o), .tx_underrun_o(tx_underrun_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_underrun_o === 1'b1) und_seen++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_load(input int j);
        exp_tx[j] = m_full ? m_hold : 8'hFF;
        if (!m_full) m_und++;
        m_full = 1'b0;
    endtask

    task automatic m_complete(input logic [7:0] v, input logic ack);
        e_ovr   = ack ? 1'b0 : (e_ovr | e_valid);
        e_valid = 1'b1;
        e_data  = v;
    endtask

    task automatic host_wr(input logic [7:0] v);
        tx_data = v; tx_wr = 1'b1; m_full = 1'b1; m_hold = v;
        tick(1);
        tx_wr = 1'b0;
        tick(1);
    endtask

    task automatic host_ack();
        rx_ack = 1'b1; e_valid = 1'b0; e_ovr = 1'b0;
        tick(1);
        rx_ack = 1'b0;
        tick(1);
    endtask

    // Master side: MOSI changes with SCLK rising, MISO captured just before SCLK falls.
    // The frame ends by raising SS before the trailing SCLK rise.
    task automatic frame(input int n, input int wr_bit, input logic [7:0] wr_val,
                         input int ack_bit, input bit lat_chk);
        ss = 1'b0; mosi = mosi_b[0][7]; m_load(0);
        tick(HP);
        for (int k = 0; k < 8 * n; k++) begin
            miso_b[k / 8][7 - (k % 8)] = miso_o;
            sclk = 1'b0;
            if (k % 8 == 7) m_complete(mosi_b[k / 8], ack_bit == k);
            if (lat_chk && k == 8 * n - 1) begin
                tick(3); check("rx_valid_lat3", {31'd0, rx_valid_o}, 32'd0);
                tick(1); check("rx_valid_lat4", {31'd0, rx_valid_o}, 32'd1);
                tick(HP - 4);
            end else if (ack_bit == k) begin
                tick(3); rx_ack = 1'b1; tick(1); rx_ack = 1'b0; tick(HP - 4);
            end else if (wr_bit == k) begin
                tx_data = wr_val; tx_wr = 1'b1; m_full = 1'b1; m_hold = wr_val;
                tick(1); tx_wr = 1'b0; tick(HP - 1);
            end else begin
                tick(HP);
            end
            if (k != 8 * n - 1) begin
                sclk = 1'b1;
                if (k % 8 == 7) m_load(k / 8 + 1);
                mosi = mosi_b[(k + 1) / 8][7 - ((k + 1) % 8)];
                tick(HP);
            end
        end
        ss = 1'b1; tick(HP);
        sclk = 1'b1; tick(HP);
    endtask

    task automatic check_frame(input int n, input string tag);
        for (int j = 0; j < n; j++) check({tag, "_miso_byte"}, {24'd0, miso_b[j]}, {24'd0, exp_tx[j]});
        check({tag, "_rx_data"}, {24'd0, rx_data_o}, {24'd0, e_data});
        check({tag, "_rx_valid"}, {31'd0, rx_valid_o}, {31'd0, e_valid});
        check({tag, "_overrun"}, {31'd0, rx_overrun_o}, {31'd0, e_ovr});
        check({tag, "_underruns"}, und_seen, m_und);
        check({tag, "_tx_full"}, {31'd0, tx_full_o}, {31'd0, m_full});
    endtask

    initial begin
        tick(2);
        check("rst_miso", {31'd0, miso_o}, 32'd1);
        check("rst_oe", {31'd0, miso_oe_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_valid", {31'd0, rx_valid_o}, 32'd0);
        check("rst_data", {24'd0, rx_data_o}, 32'd0);
        check("rst_full", {31'd0, tx_full_o}, 32'd0);
        rst_n = 1'b1;
        tick(4);

        // Single byte
        host_wr(8'hA5);
        check("tx_full_set", {31'd0, tx_full_o}, 32'd1);
        mosi_b[0] = 8'h3C;
        frame(1, -1, 8'h00, -1, 1'b1);
        check_frame(1, "single");

        // Underrun
        host_ack();
        mosi_b[0] = 8'h00;
        frame(1, -1, 8'h00, -1, 1'b0);
        check_frame(1, "underrun");

        // Two-byte frame with mid-frame write and overrun
        host_ack();
        host_wr(8'h12);
        mosi_b[0] = 8'h81; mosi_b[1] = 8'h7E;
        frame(2, 2, 8'h34, -1, 1'b0);
        check_frame(2, "two_byte");

        // Abort after 5 SCLK cycles, then a full frame
        host_ack();
        ss = 1'b0; mosi = 1'b1; m_load(0); tick(HP);
        for (int i = 0; i < 5; i++) begin
            sclk = 1'b0; tick(HP); sclk = 1'b1; tick(HP);
        end
        check("abort_busy", {31'd0, busy_o}, 32'd1);
        ss = 1'b1; tick(HP);
        check("abort_valid", {31'd0, rx_valid_o}, 32'd0);
        check("abort_ovr", {31'd0, rx_overrun_o}, 32'd0);
        check("abort_idle_miso", {31'd0, miso_o}, 32'd1);
        mosi_b[0] = 8'h55;
        frame(1, -1, 8'h00, -1, 1'b0);
        check_frame(1, "after_abort");

        // RX_ACK in the same cycle as the second byte completes
        mosi_b[0] = 8'($urandom); mosi_b[1] = 8'($urandom);
        frame(2, -1, 8'h00, 15, 1'b0);
        check_frame(2, "ack_same_cycle");

        // Reset mid-byte, SS stays low afterwards
        host_ack();
        ss = 1'b0; m_load(0); tick(HP);
        for (int i = 0; i < 3; i++) begin
            sclk = 1'b0; tick(HP); sclk = 1'b1; tick(HP);
        end
        rst_n = 1'b0;
        m_full = 1'b0; e_valid = 1'b0; e_ovr = 1'b0; e_data = 8'h00;
        tick(1);
        check("midrst_miso", {31'd0, miso_o}, 32'd1);
        check("midrst_busy", {31'd0, busy_o}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(HP);
        for (int i = 0; i < 8; i++) begin
            mosi = 1'($urandom);
            check("postrst_miso", {31'd0, miso_o}, 32'd1);
            sclk = 1'b0; tick(HP); sclk = 1'b1; tick(HP);
        end
        check("postrst_valid", {31'd0, rx_valid_o}, 32'd0);
        check("postrst_underruns", und_seen, m_und);
        ss = 1'b1; tick(HP);
        mosi_b[0] = 8'hC3;
        frame(1, -1, 8'h00, -1, 1'b0);
        check_frame(1, "post_reset_frame");

        // Randomized frames
        for (int it = 0; it < 6; it++) begin
            int n;
            int wb;
            host_ack();
            n = int'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) host_wr(8'($urandom));
            for (int j = 0; j < n; j++) mosi_b[j] = 8'($urandom);
            wb = (n > 1 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, 8 * (n - 1) - 1)) : -1;
            frame(n, wb, 8'($urandom), -1, 1'b0);
            check_frame(n, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_slave_port.md
# spi_slave_port

SPI responder for the far end of our SPI master bridge. It samples MOSI, drives MISO and delivers/accepts whole bytes on a local valid/ack byte interface. SCLK, SS and MOSI are oversampled in the single system clock domain. The block sits between an external SPI pin group and local logic (register file or FIFO), and speaks the same framing as our master: mode 2 (CPOL=1, CPHA=0), MSB first, SS active low, multi-byte frames while SS stays low.

## Interface
- IDLE_MISO, 1'b1: MISO level while SS is high.
- FILL_BYTE, 8'hFF: byte shifted out when no TX byte is pending at a byte boundary.
- CLK  input  1  system clock; all state is on its rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- SCLK  input  1  SPI clock from the master, asynchronous, idles high.
- SS  input  1  slave select from the master, asynchronous, active low.
- MOSI  input  1  master data out, asynchronous.
- MISO  output  1  slave data out; registered.
- MISO_OE  output  1  high while SS (synchronized) is low; for an external tri-state.
- TX_DATA  input  8  next byte to send.
- TX_WR  input  1  one-CLK strobe that loads TX_DATA into the TX holding register.
- TX_FULL  output  1  TX holding register occupied.
- RX_DATA  output  8  last complete received byte.
- RX_VALID  output  1  RX_DATA holds an unconsumed byte.
- RX_ACK  input  1  one-CLK strobe that consumes RX_DATA and clears RX_VALID.
- RX_OVERRUN  output  1  sticky; set when a byte completes while RX_VALID=1. Cleared by RX_ACK.
- TX_UNDERRUN  output  1  one-CLK pulse when FILL_BYTE is loaded because TX_FULL=0.
- BUSY  output  1  high while SS (synchronized) is low.

## Operation
- Synchronization:
  - SCLK, SS and MOSI each pass through 2 flops. SCLK and SS get a third flop for edge detection.
  - Edges are detected on the synchronized signals only.
- State:
  - 8-bit TX shift register `txsh` and 8-bit RX shift register `rxsh`.
  - 3-bit bit counter `bitcnt`.
  - `armed` flag: a byte boundary is pending.
- SS falling:
  - `bitcnt`=0 and `rxsh` cleared.
  - `txsh` loaded from the TX holding register, or FILL_BYTE if TX_FULL=0 (then pulse TX_UNDERRUN).
  - TX_FULL clears; MISO=`txsh[7]`.
- SCLK falling with SS low:
  - `rxsh` <= {`rxsh[6:0]`, MOSI_sync}; `bitcnt`++ (wraps 7 to 0).
  - When `bitcnt` was 7: RX_DATA <= completed byte, RX_VALID=1, and set `armed`. If RX_VALID was already 1, set RX_OVERRUN; RX_DATA is overwritten with the new byte.
- SCLK rising with SS low:
  - With `armed`: clear `armed` and load the next TX byte exactly as on SS falling (including underrun handling). MISO=new bit 7.
  - Without `armed`: `txsh` shifts left with 0 fill; MISO=new bit 7.
- SS rising:
  - A partial byte (`bitcnt`≠0) is discarded: no RX_VALID, no overrun.
  - `armed` cleared; MISO=IDLE_MISO.
  - The TX holding register is untouched.
- TX_WR:
  - Writes the holding register and sets TX_FULL.
  - TX_WR while TX_FULL=1 overwrites the previous byte.
  - TX_WR in the same CLK as a load: the load takes the old content, and the new byte then sets TX_FULL=1.
- RX_ACK in the same CLK as a byte completion: the new byte wins. RX_VALID stays 1 and RX_OVERRUN is not set.
- SCLK edges while SS is high are ignored.

## Timing
- Reset values:
  - MISO=IDLE_MISO, MISO_OE=0, BUSY=0.
  - RX_DATA=0, RX_VALID=0, RX_OVERRUN=0.
  - TX_FULL=0, TX_UNDERRUN=0.
  - `bitcnt`=0, `armed`=0; synchronizer flops reset to SCLK=1, SS=1, MOSI=1.
- Input-to-detection latency is 3 CLK from a pin edge to the internal edge pulse. MISO updates 1 CLK after detection, i.e. 4 CLK after the pin edge.
- SCLK high and low phases must each last at least 5 CLK, so MISO is stable before the master's sampling (falling) edge. The minimum SS-low-to-first-SCLK-falling time is also 5 CLK.
- RX_VALID rises 4 CLK after the 8th SCLK falling pin edge.
- RST_N assertion mid-frame aborts immediately to reset values. After release, the block waits for a fresh SS falling edge, even if SS is already low.

## Test plan
- Single byte: TX_WR 0xA5, then master sends 0x3C with SS low → MISO bits 1,0,1,0,0,1,0,1; RX_DATA=0x3C, RX_VALID=1, TX_FULL=0, TX_UNDERRUN never pulses.
- Underrun: no TX_WR, master sends 0x00 → MISO shifts 0xFF, TX_UNDERRUN pulses once at SS falling, RX_DATA=0x00.
- Two-byte frame: TX_WR 0x12 before the frame, 0x34 during byte 1; master sends 0x81,0x7E; host does not ACK → MISO 0x12 then 0x34; RX_DATA=0x7E, RX_OVERRUN=1.
- Abort: SS rises after 5 SCLK cycles with MOSI=1 → RX_VALID stays 0; the next full frame sending 0x55 yields RX_DATA=0x55.
- Same-cycle RX_ACK with the 2nd byte's completion → RX_VALID=1, RX_OVERRUN=0, RX_DATA=2nd byte.
- RST_N low mid-byte, with SS held low after release → no RX_VALID and MISO=1 until SS toggles high then low again.
